// File: rtl/period_meter.sv
`timescale 1ns/1ps
// period_meter
//   Measures a periodic signal in system-clock cycles: full period (rise to
//   rise) and the high time inside that period. sig_in is asynchronous and is
//   brought into the clk domain by a SYNC_STAGES flop chain.
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         1 = measure continuously, 0 = idle with counters cleared
//   sig_in     signal under measurement (asynchronous)
//   period     last complete period in clk cycles
//   high_time  clk cycles the signal was high within that period
//   valid      one-cycle pulse when period/high_time are updated
//   overflow   one-cycle pulse when a period exceeded 2^WIDTH-1 and was dropped
//   busy       1 while a period is being measured
module period_meter #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   s_s;
  logic                   s_d_r;
  logic                   rise_s;
  logic [WIDTH-1:0]       s_ext_s;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [WIDTH-1:0]       cnt_r;
  logic [WIDTH-1:0]       cnt_nxt_s;
  logic [WIDTH-1:0]       hcnt_r;
  logic [WIDTH-1:0]       hcnt_nxt_s;
  logic [WIDTH-1:0]       period_r;
  logic [WIDTH-1:0]       period_nxt_s;
  logic [WIDTH-1:0]       high_r;
  logic [WIDTH-1:0]       high_nxt_s;
  logic                   valid_r;
  logic                   valid_nxt_s;
  logic                   ovf_r;
  logic                   ovf_nxt_s;
  logic                   busy_r;

  assign s_s     = sync_r[SYNC_STAGES-1];
  assign rise_s  = s_s & ~s_d_r;
  assign s_ext_s = {{(WIDTH-1){1'b0}}, s_s};

  // Synchronizer chain plus one-cycle delay used for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      s_d_r  <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], sig_in};
      s_d_r  <= s_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and next-value logic for counters and result registers.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    hcnt_nxt_s   = hcnt_r;
    period_nxt_s = period_r;
    high_nxt_s   = high_r;
    valid_nxt_s  = 1'b0;
    ovf_nxt_s    = 1'b0;
    if (!en) begin
      // Disable dominates a coincident rise: no result is issued.
      state_nxt_s = IDLE;
      cnt_nxt_s   = CNT_ZERO;
      hcnt_nxt_s  = CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = WAIT_EDGE;
          cnt_nxt_s   = CNT_ZERO;
          hcnt_nxt_s  = CNT_ZERO;
        end
        WAIT_EDGE: begin
          if (rise_s) begin
            // The rise cycle itself is high and belongs to the new period.
            state_nxt_s = MEASURE;
            cnt_nxt_s   = CNT_ONE;
            hcnt_nxt_s  = CNT_ONE;
          end else begin
            state_nxt_s = WAIT_EDGE;
          end
        end
        MEASURE: begin
          if (rise_s) begin
            period_nxt_s = cnt_r;
            high_nxt_s   = hcnt_r;
            valid_nxt_s  = 1'b1;
            cnt_nxt_s    = CNT_ONE;
            hcnt_nxt_s   = CNT_ONE;
          end else if (cnt_r != CNT_MAX) begin
            // hcnt only counts cycles already counted by cnt, so it cannot wrap.
            cnt_nxt_s  = cnt_r + CNT_ONE;
            hcnt_nxt_s = hcnt_r + s_ext_s;
          end else begin
            ovf_nxt_s   = 1'b1;
            state_nxt_s = WAIT_EDGE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = CNT_ZERO;
          hcnt_nxt_s  = CNT_ZERO;
        end
      endcase
    end
  end

  // Counter, result and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= CNT_ZERO;
      hcnt_r   <= CNT_ZERO;
      period_r <= CNT_ZERO;
      high_r   <= CNT_ZERO;
      valid_r  <= 1'b0;
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      hcnt_r   <= hcnt_nxt_s;
      period_r <= period_nxt_s;
      high_r   <= high_nxt_s;
      valid_r  <= valid_nxt_s;
      ovf_r    <= ovf_nxt_s;
      busy_r   <= (state_nxt_s == MEASURE);
    end
  end

  assign period    = period_r;
  assign high_time = high_r;
  assign valid     = valid_r;
  assign overflow  = ovf_r;
  assign busy      = busy_r;

endmodule
